// File: rtl/con_pkg.sv
// Shared definitions for the convolution window feeder and the MAC engine bench:
// default sizes, window bus width, FSM encoding and the window element index.
package con_pkg;

    localparam int CON_IMA   = 8;
    localparam int CON_K     = 7;
    localparam int CON_WIN_W = CON_IMA * CON_K * CON_K;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Row-major element position inside a k x k window; row 0 / col 0 are the oldest.
    function automatic int elem_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/con_window_gen_if.sv
// Pixel-stream input and window output bundle of the window generator.
interface con_window_gen_if
    import con_pkg::*;
#(
    parameter int IMA = CON_IMA,
    parameter int K   = CON_K
);
    logic                 start;
    logic [IMA-1:0]       pix_in;
    logic                 pix_valid;
    logic                 pix_ready;
    logic [IMA*K*K-1:0]   win_out;
    logic                 win_valid;
    logic                 frame_done;

    modport master (
        output start, pix_in, pix_valid,
        input  pix_ready, win_out, win_valid, frame_done
    );

    modport slave (
        input  start, pix_in, pix_valid,
        output pix_ready, win_out, win_valid, frame_done
    );
endinterface

// File: rtl/con_line_buf.sv
// Fixed-delay pixel shift buffer: dout is the pixel pushed DEPTH shifts ago.
// Circular RAM with a registered read of the slot that becomes oldest after each push.
module con_line_buf
    import con_pkg::*;
#(
    parameter int IMA   = CON_IMA,
    parameter int DEPTH = 28
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           shift_en,
    input  logic [IMA-1:0] din,
    output logic [IMA-1:0] dout
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [IMA-1:0]   mem [DEPTH];
    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;
    logic [IMA-1:0]   dout_reg;

    assign ptr_next = (ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : ptr_reg + 1'b1;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ptr_reg <= '0;
        end else if (shift_en) begin
            ptr_reg <= ptr_next;
        end
    end

    // Contents are refilled before any window depends on them, so no reset here.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            mem[ptr_reg] <= din;
            dout_reg     <= mem[ptr_next];
        end
    end

    assign dout = dout_reg;

endmodule

// File: rtl/con_window_gen.sv
// Builds every unpadded KxK window of a raster-order frame using K-1 line buffers
// and a shifting column history; each window is strobed for one cycle.
module con_window_gen
    import con_pkg::*;
#(
    parameter int IMA   = CON_IMA,
    parameter int K     = CON_K,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic clk,
    input  logic rst_n,
    con_window_gen_if.slave bus
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int NPIX  = K * K;

    state_t                         state_reg;
    logic [COL_W-1:0]               col_reg;
    logic [ROW_W-1:0]               row_reg;
    logic                           pix_ready_reg;
    logic                           win_valid_reg;
    logic                           frame_done_reg;
    logic [K-1:0][K-2:0][IMA-1:0]   hist_reg;
    logic [K-1:0][K-2:0][IMA-1:0]   hist_next;
    logic [NPIX-1:0][IMA-1:0]       win_next;
    logic [NPIX-1:0][IMA-1:0]       win_out_reg;
    logic [K-2:0][IMA-1:0]          lb_in;
    logic [K-2:0][IMA-1:0]          lb_out;
    logic [K-1:0][IMA-1:0]          col_pix;
    logic                           xfer;
    logic                           last_col;
    logic                           last_row;
    logic                           win_pos;

    assign xfer     = bus.pix_valid && pix_ready_reg;
    assign last_col = (col_reg == COL_W'(IMG_W - 1));
    assign last_row = (row_reg == ROW_W'(IMG_H - 1));
    assign win_pos  = (row_reg >= ROW_W'(K - 1)) && (col_reg >= COL_W'(K - 1));

    genvar gi, gj;

    // Chain of line buffers: buffer 0 sees the live pixel, each later one the previous output.
    generate
        for (gi = 0; gi < K - 1; gi++) begin : g_lb
            if (gi == 0) begin : g_head
                assign lb_in[gi] = bus.pix_in;
            end else begin : g_tail
                assign lb_in[gi] = lb_out[gi-1];
            end
            con_line_buf #(
                .IMA   (IMA),
                .DEPTH (IMG_W)
            ) u_lb (
                .clk      (clk),
                .rst_n    (rst_n),
                .shift_en (xfer),
                .din      (lb_in[gi]),
                .dout     (lb_out[gi])
            );
            assign col_pix[gi] = lb_out[K-2-gi];
        end
    endgenerate

    assign col_pix[K-1] = bus.pix_in;

    // Only the newest K-1 columns are kept; the oldest one falls off as the new column enters.
    generate
        for (gi = 0; gi < K; gi++) begin : g_row
            for (gj = 0; gj < K; gj++) begin : g_col
                if (gj == K - 1) begin : g_new
                    assign win_next[elem_idx(gi, gj, K)] = col_pix[gi];
                end else begin : g_old
                    assign win_next[elem_idx(gi, gj, K)] = hist_reg[gi][gj];
                    assign hist_next[gi][gj]             = win_next[elem_idx(gi, gj + 1, K)];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_reg      <= IDLE;
            col_reg        <= '0;
            row_reg        <= '0;
            pix_ready_reg  <= 1'b0;
            win_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            win_valid_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg     <= STREAM;
                        col_reg       <= '0;
                        row_reg       <= '0;
                        pix_ready_reg <= 1'b1;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        win_valid_reg <= win_pos;
                        if (last_col) begin
                            col_reg <= '0;
                            if (last_row) begin
                                state_reg      <= DONE;
                                pix_ready_reg  <= 1'b0;
                                frame_done_reg <= 1'b1;
                            end else begin
                                row_reg <= row_reg + 1'b1;
                            end
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg     <= IDLE;
                    pix_ready_reg <= 1'b0;
                end
            endcase
        end
    end

    // History shifts on every transfer; the output only loads on a complete window.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            hist_reg    <= '0;
            win_out_reg <= '0;
        end else if (xfer) begin
            hist_reg <= hist_next;
            if (win_pos) begin
                win_out_reg <= win_next;
            end
        end
    end

    assign bus.pix_ready  = pix_ready_reg;
    assign bus.win_valid  = win_valid_reg;
    assign bus.frame_done = frame_done_reg;
    assign bus.win_out    = win_out_reg;

endmodule

// File: tb/tb_con_window_gen.sv
// Bench for con_window_gen: a frame-memory reference model predicts every window,
// strobe and frame_done; directed frames add hand-computed expectations.
module tb_con_window_gen;
    import con_pkg::*;

    localparam int IMA = 8;
    localparam int K   = 7;
    localparam int W   = 28;
    localparam int H   = 28;
    localparam int N   = W * H;
    localparam int WW  = IMA * K * K;
    localparam int SK  = 3;
    localparam int SWW = IMA * SK * SK;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    con_window_gen_if #(.IMA(IMA), .K(K))  bus ();
    con_window_gen_if #(.IMA(IMA), .K(SK)) s_bus ();

    con_window_gen #(.IMA(IMA), .K(K), .IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    con_window_gen #(.IMA(IMA), .K(SK), .IMG_W(5), .IMG_H(4)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint elem(input logic [WW-1:0] w, input int i);
        return longint'(w[i*IMA +: IMA]);
    endfunction

    // Reference model: remember the frame by pixel index and cut windows out of it.
    logic [IMA-1:0] frame_mem [N];
    int             p = 0;
    int             mr, mc;
    bit             xfer_seen = 1'b0;
    bit             exp_wv = 1'b0;
    bit             exp_fd = 1'b0;
    logic [WW-1:0]  exp_win = '0;

    always @(posedge clk) begin
        if (rst_n) begin
            p         = 0;
            xfer_seen = 1'b0;
            exp_wv    = 1'b0;
            exp_fd    = 1'b0;
            exp_win   = '0;
        end else begin
            xfer_seen = bus.pix_valid && bus.pix_ready;
            exp_wv    = 1'b0;
            exp_fd    = 1'b0;
            if (xfer_seen) begin
                frame_mem[p] = bus.pix_in;
                mr = p / W;
                mc = p % W;
                if (mr >= K - 1 && mc >= K - 1) begin
                    exp_wv = 1'b1;
                    for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++)
                            exp_win[(i*K+j)*IMA +: IMA] = frame_mem[(mr-K+1+i)*W + (mc-K+1+j)];
                end
                exp_fd = (p == N - 1);
                p = (p + 1) % N;
            end
        end
    end

    logic [WW-1:0] win_log [$];
    logic [WW-1:0] ref_log [$];
    int            win_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("win_valid", longint'(bus.win_valid), longint'(exp_wv));
            chk("frame_done", longint'(bus.frame_done), longint'(exp_fd));
            n_cmp++;
            if (bus.win_out !== exp_win) begin
                n_bad++;
                $display("FAIL win_out: got %h, expected %h", bus.win_out, exp_win);
            end
            if (bus.win_valid) begin
                win_log.push_back(bus.win_out);
                win_cnt++;
            end
        end
    end

    task automatic run_frame(input string tag, input int pct, input bit rand_data,
                             input int rst_at, input bit start_mid, output int cyc_fd);
        int idx = 0;
        int cyc = 0;
        bit done = 1'b0;
        logic [IMA-1:0] src [N];
        for (int k = 0; k < N; k++) src[k] = rand_data ? IMA'($urandom) : IMA'(k);
        win_cnt = 0;
        win_log.delete();
        cyc_fd = -1;
        @(negedge clk);
        bus.start     = 1'b1;
        bus.pix_in    = src[0];
        bus.pix_valid = ($urandom_range(0, 99) < pct);
        while (!done && cyc < 6000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.frame_done) begin
                done = 1'b1;
            end else if (rst_at >= 0 && idx >= rst_at) begin
                #1;
                rst_n         = 1'b1;
                bus.pix_valid = 1'b0;
                bus.start     = 1'b0;
                #1;
                chk({tag, "_rst_ready"}, longint'(bus.pix_ready), 0);
                chk({tag, "_rst_wvalid"}, longint'(bus.win_valid), 0);
                chk({tag, "_rst_fdone"}, longint'(bus.frame_done), 0);
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk({tag, "_idle_ready"}, longint'(bus.pix_ready), 0);
                end
                return;
            end else begin
                @(negedge clk);
                if (xfer_seen) idx++;
                bus.start     = start_mid && (cyc == 50 || cyc == 400 || cyc == 784);
                bus.pix_in    = src[(idx < N) ? idx : N-1];
                bus.pix_valid = (idx < N) && ($urandom_range(0, 99) < pct);
            end
        end
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.start     = 1'b0;
        if (!done) chk({tag, "_timeout"}, 1, 0);
        cyc_fd = cyc;
        repeat (3) @(negedge clk);
    endtask

    int cyc;
    int seq_bad;
    int s_idx;
    bit s_rdy;
    bit s_done;
    bit s_fd_wv;
    logic [SWW-1:0] s_log [$];
    int s_exp [9];

    initial begin
        bus.start = 1'b0;  bus.pix_in = '0;  bus.pix_valid = 1'b0;
        s_bus.start = 1'b0; s_bus.pix_in = '0; s_bus.pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", longint'(bus.pix_ready), 0);
        chk("reset_wvalid", longint'(bus.win_valid), 0);
        chk("reset_fdone", longint'(bus.frame_done), 0);
        chk("reset_win_zero", longint'(bus.win_out == '0), 1);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Ramp frame, continuous valid: pins the model with literal window values.
        run_frame("f1", 100, 1'b0, -1, 1'b0, cyc);
        chk("f1_cycles", cyc, 785);
        chk("f1_count", win_cnt, 484);
        if (win_log.size() == 484) begin
            chk("f1_w0_e0", elem(win_log[0], 0), 0);
            chk("f1_w0_e6", elem(win_log[0], 6), 6);
            chk("f1_w0_e42", elem(win_log[0], 42), 168);
            chk("f1_w0_e48", elem(win_log[0], 48), 174);
            chk("f1_wrap_e0", elem(win_log[22], 0), 28);
            chk("f1_wrap_e48", elem(win_log[22], 48), 202);
            chk("f1_last_e48", elem(win_log[483], 48), 15);
        end
        ref_log = win_log;

        // Same ramp with gaps in pix_valid: window sequence must not change.
        run_frame("f2", 50, 1'b0, -1, 1'b0, cyc);
        chk("f2_count", win_cnt, 484);
        seq_bad = 0;
        for (int i = 0; i < 484; i++)
            if (i >= win_log.size() || i >= ref_log.size() || win_log[i] !== ref_log[i]) seq_bad++;
        chk("f2_seq_diff", seq_bad, 0);

        run_frame("f3", 70, 1'b1, -1, 1'b0, cyc);
        chk("f3_count", win_cnt, 484);

        run_frame("f4", 100, 1'b0, 300, 1'b0, cyc);
        run_frame("f4b", 100, 1'b0, -1, 1'b0, cyc);
        chk("f4b_count", win_cnt, 484);
        chk("f4b_cycles", cyc, 785);

        run_frame("f5", 100, 1'b0, -1, 1'b1, cyc);
        chk("f5_count", win_cnt, 484);
        chk("f5_cycles", cyc, 785);
        chk("f5_idle_after", longint'(bus.pix_ready), 0);

        // Small geometry K=3, 5x4 ramp.
        s_exp = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        s_idx = 0;
        s_done = 1'b0;
        s_fd_wv = 1'b0;
        @(negedge clk);
        s_bus.start = 1'b1;
        s_bus.pix_in = '0;
        s_bus.pix_valid = 1'b1;
        for (int c = 0; c < 200 && !s_done; c++) begin
            s_rdy = s_bus.pix_ready;
            @(posedge clk);
            #1;
            if (s_rdy && s_bus.pix_valid) s_idx++;
            if (s_bus.win_valid) s_log.push_back(s_bus.win_out);
            if (s_bus.frame_done) begin
                s_done = 1'b1;
                s_fd_wv = s_bus.win_valid;
            end
            @(negedge clk);
            s_bus.start = 1'b0;
            s_bus.pix_in = IMA'(s_idx);
            s_bus.pix_valid = (s_idx < 20);
        end
        s_bus.pix_valid = 1'b0;
        chk("s_done", longint'(s_done), 1);
        chk("s_count", s_log.size(), 6);
        chk("s_fd_with_valid", longint'(s_fd_wv), 1);
        if (s_log.size() == 6) begin
            for (int i = 0; i < 9; i++)
                chk($sformatf("s_first_e%0d", i), longint'(s_log[0][i*IMA +: IMA]), s_exp[i]);
            chk("s_last_e8", longint'(s_log[5][8*IMA +: IMA]), 19);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/con_window_gen.md
Name: con_window_gen

Overview:
- Feeder for the 7x7 convolution MAC engine.
- Accepts a raster-order 8-bit pixel stream for one frame and builds every valid (unpadded) KxK window with K-1 line buffers and a KxK shift-register window.
- Presents each window on a packed bus that matches the engine's image input, with a one-cycle valid strobe.
- The engine is fully pipelined, so there is no output backpressure.

Parameters:
- IMA, 8, pixel width in bits
- K, 7, window size (window holds K*K = 49 pixels)
- IMG_W, 28, frame width in pixels (must be >= K)
- IMG_H, 28, frame height in pixels (must be >= K)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-high reset (asserted = 1); name kept for port compatibility
- start  in  1  arms capture of one frame; honoured only in IDLE
- pix_in  in  IMA  pixel data
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  block accepts a pixel; a pixel transfers when pix_valid && pix_ready
- win_out  out  IMA*K*K  window; element idx = r*K+c sits at [(idx+1)*IMA-1 : idx*IMA]; r=0 is the top (oldest) row, c=0 is the left (oldest) column
- win_valid  out  1  win_out holds a new valid window (one-cycle strobe)
- frame_done  out  1  one-cycle pulse at the end of the frame

Behaviour:
- Reset: state IDLE; col, row and all counters 0; window registers 0; pix_ready=0, win_valid=0, frame_done=0. Line-buffer contents are not reset; they are don't-care because they are refilled before any window is valid.
- FSM:
  - IDLE: pix_ready=0. start=1 → STREAM; counters are cleared on entry.
  - STREAM: pix_ready=1. Each transfer increments col. When col==IMG_W-1, col wraps to 0 and row increments.
  - STREAM → DONE on transfer of the last pixel (row==IMG_H-1, col==IMG_W-1).
  - DONE: pix_ready=0; frame_done=1 for exactly this cycle → IDLE.
- Per transfer:
  - Each line buffer (depth IMG_W) pops its oldest pixel and pushes a new one. Buffer 0 takes pix_in; buffer j takes buffer j-1's output.
  - The new window column, top to bottom, is {buf K-2 out, ..., buf 0 out, pix_in}.
  - The window shifts left one column and the new column enters at c=K-1.
- No transfer (pix_valid=0) → nothing shifts; win_valid=0.
- Window validity: win_valid=1 on the cycle after a transfer whose (row,col) satisfies row>=K-1 and col>=K-1. win_out is registered and updates on that same edge, so latency is 1 cycle.
- Windows that straddle a row wrap (col<K-1) are suppressed.
- Windows per frame: (IMG_H-K+1)*(IMG_W-K+1), which is 484 for the defaults.
- The last window's win_valid coincides with frame_done (DONE cycle).
- start while in STREAM or DONE: ignored.
- start held high at DONE→IDLE: a new frame begins the following cycle (IDLE sees start).
- rst_n asserted mid-frame: immediate return to reset values; any partial frame is discarded; the next frame requires start.
- win_out holds its last value when win_valid=0.
- Widths: col counter clog2(IMG_W), row counter clog2(IMG_H); no arithmetic on pixel data.

Decomposition:
- Package con_pkg holds:
  - IMA and K defaults
  - window bus width IMA*K*K
  - FSM state encoding (IDLE/STREAM/DONE)
  - the element-index function idx=r*K+c, shared with the MAC engine's bench
- One sub-module, con_line_buf: a shift buffer of IMA bits by IMG_W deep with a shift enable. Output = the pixel pushed IMG_W shifts ago. Instantiated K-1 times via generate.

Test Plan:
- Default params; start pulse; 784-pixel ramp, pixel = (r*28+c) mod 256, pix_valid held 1 → first win_valid one cycle after pixel 174 (r6,c6). Element 0 = 0, element 6 = 6, element 42 = 168, element 48 = 174. Exactly 484 strobes. frame_done coincides with the last strobe, whose element 48 = 783 mod 256 = 15.
- Same frame with pix_valid randomly low ~50% → identical sequence of 484 window contents; win_valid never asserts in a cycle with no preceding transfer.
- Check the row wrap at pixel r7,c0..c5 → no win_valid; pixel r7,c6 → window with element 0 = 28 (r1,c0).
- Params K=3, IMG_W=5, IMG_H=4; ramp 0..19 → 6 windows. The first window is {0,1,2,5,6,7,10,11,12}; the last has element 8 = 19.
- rst_n pulsed at pixel 300 → pix_ready=0, win_valid=0, state IDLE. A new start and a full frame gives 484 correct windows.
- start pulsed during STREAM → no effect: the window count and frame_done timing are unchanged.
